// File: rtl/clk_speed_ctrl_pkg.sv
// Shared front-panel speed-control definitions: mode encoding and width,
// reused by the CPU top and the display logic.
package clk_speed_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN_SLOW = 2'd0,
    MODE_RUN_FAST = 2'd1,
    MODE_STEP     = 2'd2,
    MODE_ILLEGAL  = 2'd3
  } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// One front-panel input: 2-flop synchroniser, strobe-paced sample history,
// debounced level and a one-clk pulse on its rising edge.
module btn_debounce #(
  parameter int DEB_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic               sync1_q, sync2_q;
  logic [DEB_LEN-1:0] hist_q, hist_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;

  // History shift on strobe; level flips only once the whole history agrees.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (strobe) begin
      hist_d = {hist_q[DEB_LEN-2:0], sync2_q};
    end else begin
      hist_d = hist_q;
    end
    if ((hist_q == {DEB_LEN{1'b1}}) && !level_q) begin
      level_d = 1'b1;
    end else if ((hist_q == {DEB_LEN{1'b0}}) && level_q) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
    rise_d = level_d & ~level_q;
  end

  // Synchroniser, history and debounced state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= {DEB_LEN{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/clk_speed_ctrl.sv
// Front-panel clock speed control: debounces speed/step/run inputs and runs
// the RUN_SLOW / RUN_FAST / STEP mode machine feeding the CPU clock divider.
module clk_speed_ctrl
  import clk_speed_ctrl_pkg::*;
#(
  parameter int DEB_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_src,
  input  logic             btn_speed,
  input  logic             btn_step,
  input  logic             sw_run,
  output logic             speed_select,
  output logic             cpu_run,
  output logic             step_pulse,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  logic tick_s1_q, tick_s2_q, tick_prev_q;
  logic strobe_s;
  logic speed_lvl, speed_rise, step_lvl, step_rise, run_lvl, run_rise;
  logic deb_unused;

  mode_e            state_q, state_d;
  logic             speed_select_q, speed_select_d;
  logic             cpu_run_q, cpu_run_d;
  logic             step_pulse_q, step_pulse_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             step_fire_s;

  assign strobe_s = tick_s2_q & ~tick_prev_q;

  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_speed (
    .clk(clk), .reset_n(reset_n), .strobe(strobe_s), .raw(btn_speed),
    .level(speed_lvl), .rise(speed_rise)
  );
  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_step (
    .clk(clk), .reset_n(reset_n), .strobe(strobe_s), .raw(btn_step),
    .level(step_lvl), .rise(step_rise)
  );
  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_run (
    .clk(clk), .reset_n(reset_n), .strobe(strobe_s), .raw(sw_run),
    .level(run_lvl), .rise(run_rise)
  );

  // Only the speed/step press pulses and the run level drive the FSM.
  assign deb_unused = ^{speed_lvl, step_lvl, run_rise};

  // Next mode in priority order, plus registered outputs of the entered state.
  always_comb begin
    state_d        = state_q;
    speed_select_d = speed_select_q;
    cpu_run_d      = cpu_run_q;
    step_pulse_d   = 1'b0;
    step_count_d   = step_count_q;
    case (state_q)
      MODE_RUN_SLOW: begin
        if (!run_lvl) state_d = MODE_STEP;
        else if (speed_rise) state_d = MODE_RUN_FAST;
        else state_d = MODE_RUN_SLOW;
      end
      MODE_RUN_FAST: begin
        if (!run_lvl) state_d = MODE_STEP;
        else if (speed_rise) state_d = MODE_RUN_SLOW;
        else state_d = MODE_RUN_FAST;
      end
      MODE_STEP: begin
        if (run_lvl) state_d = MODE_RUN_SLOW;
        else state_d = MODE_STEP;
      end
      default: state_d = MODE_RUN_SLOW;
    endcase
    speed_select_d = (state_d != MODE_RUN_FAST);
    cpu_run_d      = (state_d == MODE_RUN_SLOW) || (state_d == MODE_RUN_FAST);
    // A step counts only when STEP is both the current and the next state.
    step_fire_s    = (state_q == MODE_STEP) && (state_d == MODE_STEP) && step_rise;
    step_pulse_d   = step_fire_s;
    if (step_fire_s) begin
      step_count_d = step_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      step_count_d = step_count_q;
    end
  end

  // Tick synchroniser/edge register and FSM/output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_s1_q      <= 1'b0;
      tick_s2_q      <= 1'b0;
      tick_prev_q    <= 1'b0;
      state_q        <= MODE_RUN_SLOW;
      speed_select_q <= 1'b1;
      cpu_run_q      <= 1'b1;
      step_pulse_q   <= 1'b0;
      step_count_q   <= {CNT_W{1'b0}};
    end else begin
      tick_s1_q      <= tick_src;
      tick_s2_q      <= tick_s1_q;
      tick_prev_q    <= tick_s2_q;
      state_q        <= state_d;
      speed_select_q <= speed_select_d;
      cpu_run_q      <= cpu_run_d;
      step_pulse_q   <= step_pulse_d;
      step_count_q   <= step_count_d;
    end
  end

  assign mode         = state_q;
  assign speed_select = speed_select_q;
  assign cpu_run      = cpu_run_q;
  assign step_pulse   = step_pulse_q;
  assign step_count   = step_count_q;

endmodule
